// File: rtl/snitch_sb_ipool_pkg.sv
// Shared helpers for the scoreboard index pool.
// Latency: n/a (constants and combinational helper only).
// Backpressure: n/a.
package snitch_sb_ipool_pkg;

    // Widest pool the count helper supports.
    localparam int unsigned IpoolMaxDepth = 64;

    // Population count over a mask zero-extended to the maximum pool width.
    function automatic int unsigned ipool_ones(input logic [IpoolMaxDepth-1:0] mask);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < IpoolMaxDepth; i++) begin
            cnt += int'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/snitch_sb_ipool_pick.sv
// Lowest-set-bit selector: one-hot of the lowest set bit of mask, zero if mask is empty.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mask (Depth-bit candidate set), onehot (Depth-bit selection).
module snitch_sb_ipool_pick #(
    parameter int unsigned Depth = 4
) (
    input  logic [Depth-1:0] mask,
    output logic [Depth-1:0] onehot
);

    logic found;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (mask[i] && !found) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snitch_sb_ipool.sv
// Free pool of one-hot indices: allocate lowest free index on pop, return indices on push.
// Latency: outputs are combinational from the free mask; pushes/pops take effect at the next edge.
// Backpressure: none; pop while empty is ignored, callers gate pop_i with empty_o.
// Ports: clk_i, rst_i (sync, active-high), data_i/push_i (return), data_o/pop_i (allocate),
//        full_o, empty_o, usage_o (count of free indices).
// Optional: define SNITCH_SB_IPOOL_CHECKS_EN for simulation-only misuse warnings.
module snitch_sb_ipool
    import snitch_sb_ipool_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [Depth-1:0]           data_i,
    input  logic                       push_i,
    output logic [Depth-1:0]           data_o,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] usage_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    // Bit i set means index i is available for allocation.
    logic [Depth-1:0] free_q;
    logic [Depth-1:0] free_d;
    logic [Depth-1:0] pick;

    snitch_sb_ipool_pick #(
        .Depth (Depth)
    ) i_pick (
        .mask   (free_q),
        .onehot (pick)
    );

    assign data_o  = pick;
    assign usage_o = CntW'(ipool_ones(IpoolMaxDepth'(free_q)));
    assign full_o  = (usage_o == CntW'(Depth));
    assign empty_o = (usage_o == '0);

    // Clear is applied before set so a returned index wins over a same-cycle allocation.
    always_comb begin
        free_d = free_q;
        if (pop_i && !empty_o) begin
            free_d = free_d & ~pick;
        end
        if (push_i) begin
            free_d = free_d | data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_q <= '1;
        end else begin
            free_q <= free_d;
        end
    end

`ifdef SNITCH_SB_IPOOL_CHECKS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (pop_i && empty_o) begin
                $warning("snitch_sb_ipool: pop while empty");
            end
            if (push_i && ((data_i & free_q) != '0)) begin
                $warning("snitch_sb_ipool: push of already-free index %b", data_i);
            end
            if (push_i && !$onehot(data_i)) begin
                $warning("snitch_sb_ipool: push with non-one-hot data %b", data_i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_snitch_sb_ipool.sv
module tb_snitch_sb_ipool;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] usage;
        logic       full;
        logic       empty;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       push;
        logic       pop;
        logic [3:0] din;
        exp_t       e;
    } stim_t;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b0;
    logic [3:0] data_i  = '0;
    logic       push_i  = 1'b0;
    logic [3:0] data_o;
    logic       pop_i   = 1'b0;
    logic       full_o;
    logic       empty_o;
    logic [2:0] usage_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    snitch_sb_ipool #(
        .Depth (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .push_i  (push_i),
        .data_o  (data_o),
        .pop_i   (pop_i),
        .full_o  (full_o),
        .empty_o (empty_o),
        .usage_o (usage_o)
    );

    task automatic test_reset();
        stim_t tbl[$];
        exp_t  e, obs;
        // Reset with stray push/pop still yields a fully free pool.
        tbl = '{'{1'b1, 1'b1, 1'b1, 4'b0000, '{4'b0001, 3'd4, 1'b1, 1'b0}},
                '{1'b0, 1'b0, 1'b0, 4'b1111, '{4'b0001, 3'd4, 1'b1, 1'b0}}};
        foreach (tbl[i]) begin
            rst_i = tbl[i].rst; push_i = tbl[i].push; pop_i = tbl[i].pop; data_i = tbl[i].din;
            exp_q.push_back(tbl[i].e);
            @(posedge clk_i); #1;
            e   = exp_q.pop_front();
            obs = '{data_o, usage_o, full_o, empty_o};
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got data=%b usage=%0d full=%b empty=%b want data=%b usage=%0d full=%b empty=%b",
                         i, obs.data, obs.usage, obs.full, obs.empty, e.data, e.usage, e.full, e.empty);
            end
        end
        rst_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; data_i = '0;
    endtask

    task automatic test_drain();
        stim_t tbl[$];
        exp_t  e, obs;
        tbl = '{'{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0010, 3'd3, 1'b0, 1'b0}},
                '{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0100, 3'd2, 1'b0, 1'b0}},
                '{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b1000, 3'd1, 1'b0, 1'b0}},
                '{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0000, 3'd0, 1'b0, 1'b1}}};
        foreach (tbl[i]) begin
            rst_i = tbl[i].rst; push_i = tbl[i].push; pop_i = tbl[i].pop; data_i = tbl[i].din;
            exp_q.push_back(tbl[i].e);
            @(posedge clk_i); #1;
            e   = exp_q.pop_front();
            obs = '{data_o, usage_o, full_o, empty_o};
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL drain[%0d] got data=%b usage=%0d full=%b empty=%b want data=%b usage=%0d full=%b empty=%b",
                         i, obs.data, obs.usage, obs.full, obs.empty, e.data, e.usage, e.full, e.empty);
            end
        end
        pop_i = 1'b0;
    endtask

    task automatic test_pop_empty();
        stim_t tbl[$];
        exp_t  e, obs;
        tbl = '{'{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0000, 3'd0, 1'b0, 1'b1}},
                '{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0000, 3'd0, 1'b0, 1'b1}},
                '{1'b0, 1'b0, 1'b0, 4'b1010, '{4'b0000, 3'd0, 1'b0, 1'b1}}};
        foreach (tbl[i]) begin
            rst_i = tbl[i].rst; push_i = tbl[i].push; pop_i = tbl[i].pop; data_i = tbl[i].din;
            exp_q.push_back(tbl[i].e);
            @(posedge clk_i); #1;
            e   = exp_q.pop_front();
            obs = '{data_o, usage_o, full_o, empty_o};
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL pop_empty[%0d] got data=%b usage=%0d full=%b empty=%b want data=%b usage=%0d full=%b empty=%b",
                         i, obs.data, obs.usage, obs.full, obs.empty, e.data, e.usage, e.full, e.empty);
            end
        end
        pop_i = 1'b0; data_i = '0;
    endtask

    task automatic test_return();
        stim_t tbl[$];
        exp_t  e, obs;
        // Return index 2, return it again (idempotent), then return 0 which becomes the pick.
        tbl = '{'{1'b0, 1'b1, 1'b0, 4'b0100, '{4'b0100, 3'd1, 1'b0, 1'b0}},
                '{1'b0, 1'b1, 1'b0, 4'b0100, '{4'b0100, 3'd1, 1'b0, 1'b0}},
                '{1'b0, 1'b1, 1'b0, 4'b0001, '{4'b0001, 3'd2, 1'b0, 1'b0}},
                '{1'b0, 1'b1, 1'b0, 4'b1010, '{4'b0001, 3'd4, 1'b1, 1'b0}}};
        foreach (tbl[i]) begin
            rst_i = tbl[i].rst; push_i = tbl[i].push; pop_i = tbl[i].pop; data_i = tbl[i].din;
            exp_q.push_back(tbl[i].e);
            @(posedge clk_i); #1;
            e   = exp_q.pop_front();
            obs = '{data_o, usage_o, full_o, empty_o};
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL return[%0d] got data=%b usage=%0d full=%b empty=%b want data=%b usage=%0d full=%b empty=%b",
                         i, obs.data, obs.usage, obs.full, obs.empty, e.data, e.usage, e.full, e.empty);
            end
        end
        push_i = 1'b0; data_i = '0;
    endtask

    task automatic test_simultaneous();
        stim_t tbl[$];
        exp_t  e, obs;
        // Start full: pop 0,2,3 via reset-free path to reach mask 0010, then push+pop cases.
        tbl = '{'{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0010, 3'd3, 1'b0, 1'b0}},
                '{1'b0, 1'b1, 1'b1, 4'b0001, '{4'b0001, 3'd3, 1'b0, 1'b0}},
                '{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0100, 3'd2, 1'b0, 1'b0}},
                '{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b1000, 3'd1, 1'b0, 1'b0}},
                '{1'b0, 1'b1, 1'b1, 4'b0010, '{4'b0010, 3'd1, 1'b0, 1'b0}},
                '{1'b0, 1'b1, 1'b1, 4'b0001, '{4'b0001, 3'd1, 1'b0, 1'b0}},
                '{1'b0, 1'b1, 1'b1, 4'b0001, '{4'b0001, 3'd1, 1'b0, 1'b0}}};
        foreach (tbl[i]) begin
            rst_i = tbl[i].rst; push_i = tbl[i].push; pop_i = tbl[i].pop; data_i = tbl[i].din;
            exp_q.push_back(tbl[i].e);
            @(posedge clk_i); #1;
            e   = exp_q.pop_front();
            obs = '{data_o, usage_o, full_o, empty_o};
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL simultaneous[%0d] got data=%b usage=%0d full=%b empty=%b want data=%b usage=%0d full=%b empty=%b",
                         i, obs.data, obs.usage, obs.full, obs.empty, e.data, e.usage, e.full, e.empty);
            end
        end
        push_i = 1'b0; pop_i = 1'b0; data_i = '0;
    endtask

    task automatic test_mid_reset();
        stim_t tbl[$];
        exp_t  e, obs;
        tbl = '{'{1'b1, 1'b0, 1'b0, 4'b0000, '{4'b0001, 3'd4, 1'b1, 1'b0}},
                '{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0010, 3'd3, 1'b0, 1'b0}},
                '{1'b0, 1'b0, 1'b1, 4'b0000, '{4'b0100, 3'd2, 1'b0, 1'b0}},
                '{1'b0, 1'b0, 1'b0, 4'b0000, '{4'b0100, 3'd2, 1'b0, 1'b0}},
                '{1'b1, 1'b0, 1'b1, 4'b0000, '{4'b0001, 3'd4, 1'b1, 1'b0}}};
        foreach (tbl[i]) begin
            rst_i = tbl[i].rst; push_i = tbl[i].push; pop_i = tbl[i].pop; data_i = tbl[i].din;
            exp_q.push_back(tbl[i].e);
            @(posedge clk_i); #1;
            e   = exp_q.pop_front();
            obs = '{data_o, usage_o, full_o, empty_o};
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mid_reset[%0d] got data=%b usage=%0d full=%b empty=%b want data=%b usage=%0d full=%b empty=%b",
                         i, obs.data, obs.usage, obs.full, obs.empty, e.data, e.usage, e.full, e.empty);
            end
        end
        rst_i = 1'b0; pop_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_drain();
        test_pop_empty();
        test_return();
        test_simultaneous();
        test_mid_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snitch_sb_ipool.md
SNITCH_SB_IPOOL -- requirements
Module: snitch_sb_ipool

Interface
REQ-001 SHALL have parameter Depth, default 4, number of one-hot indices managed (legal range 1..64).
REQ-002 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rst_i, input, 1; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port data_i, input, Depth, one-hot index being returned to the pool.
REQ-005 SHALL have port push_i, input, 1, return data_i to pool this cycle.
REQ-006 SHALL have port data_o, output, Depth, one-hot next free index; all-zero when pool empty.
REQ-007 SHALL have port pop_i, input, 1, consume data_o this cycle.
REQ-008 SHALL have port full_o, output, 1, all Depth indices free.
REQ-009 SHALL have port empty_o, output, 1, no index free.
REQ-010 SHALL have port usage_o, output, $clog2(Depth+1), count of free indices (0..Depth).

Function
REQ-011 SHALL hold state as a Depth-bit free mask; bit i set = index i available.
REQ-012 SHALL drive data_o combinationally as one-hot of the lowest-numbered set bit of the free mask; zero latency from state.
REQ-013 SHALL derive usage_o = popcount(free mask), full_o = (usage_o == Depth), empty_o = (usage_o == 0), all combinational from state.
REQ-014 SHALL, on pop_i with empty_o=0, clear the data_o bit at the next edge.
REQ-015 SHALL ignore pop_i while empty_o=1 (no state change).
REQ-016 SHALL, on push_i, set every bit of data_i in the free mask at the next edge; pushing an already-free index leaves it free, usage unchanged.
REQ-017 SHALL apply simultaneous push_i and pop_i in the same edge; the set from push takes priority over the clear from pop for the same bit.
REQ-018 SHALL ignore data_i when push_i=0 and have no handshake/back-pressure; callers gate pop_i with empty_o.
REQ-019 SHALL keep state unchanged when neither push_i nor pop_i is asserted.

Reset
REQ-020 SHALL, while rst_i=1 at a rising edge, set free mask to all ones regardless of push_i/pop_i.
REQ-021 SHALL present after reset: usage_o=Depth, full_o=1, empty_o=0, data_o=one-hot bit 0.
REQ-022 SHALL discard any in-flight allocation on reset mid-operation; all indices become free.

Configuration
REQ-023 SHALL, when SNITCH_SB_IPOOL_CHECKS_EN is defined, include simulation-only checks that print a warning on: pop_i while empty, push_i of an index already free, push_i with non-one-hot data_i.
REQ-024 SHALL, without SNITCH_SB_IPOOL_CHECKS_EN, omit all checks with identical functional behaviour.

Structure
REQ-025 SHALL need no shared-package typedefs; count width derived locally from Depth.
REQ-026 SHALL implement the lowest-set-bit selector as sub-module snitch_sb_ipool_pick (Depth-bit mask in, one-hot out, zero when mask empty).

Verification (Depth=4)
REQ-027 SHALL verify reset: rst_i=1 one cycle -> usage_o=4, full_o=1, empty_o=0, data_o=0001.
REQ-028 SHALL verify drain: pop_i four cycles -> data_o 0001,0010,0100,1000, usage_o 3,2,1,0, then empty_o=1, data_o=0000.
REQ-029 SHALL verify return: from empty, push_i with data_i=0100 -> data_o=0100, usage_o=1, empty_o=0.
REQ-030 SHALL verify simultaneous: free mask 0010, push_i data_i=0001 plus pop_i -> free mask 0001, usage_o=1, data_o=0001.
REQ-031 SHALL verify pop when empty: empty, pop_i=1 -> usage_o stays 0, data_o=0000.
REQ-032 SHALL verify mid-operation reset: after two pops, rst_i=1 with pop_i=1 -> usage_o=4, data_o=0001.
